// File: rtl/rs_enc_lfsr.sv
// rs_enc_lfsr -- systematic Reed-Solomon encoder over GF(2^8).
// The message symbols are passed straight through to the output. An NPAR-stage
// LFSR collects the division remainder, and NPAR parity symbols follow the
// message, highest-degree symbol first.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active low
//   g_coef     generator coefficients g[0]..g[NPAR-1], 8 bits each; the x^NPAR
//              term is implicit
//   in_data    message symbol
//   in_valid   in_data is valid
//   in_ready   the block accepts in_data this cycle
//   out_data   codeword symbol (registered)
//   out_valid  out_data is valid
//   out_ready  downstream accepts out_data
//   out_last   marks the final parity symbol of a codeword

// Generic GF(2^8) multiply: shift-and-add, reducing by PRIM at each shift.
module rs_gf_mul #(
  parameter logic [8:0] PRIM = 9'h11D
) (
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  output logic [7:0] o_p
);
  logic [7:0] w_acc;
  logic [7:0] w_sh;

  always_comb begin
    w_acc = '0;
    w_sh  = i_a;
    for (int i = 0; i < 8; i++) begin
      if (i_b[i]) w_acc = w_acc ^ w_sh;
      w_sh = {w_sh[6:0], 1'b0} ^ (w_sh[7] ? PRIM[7:0] : 8'h00);
    end
  end

  assign o_p = w_acc;
endmodule

module rs_enc_lfsr #(
  parameter int         NPAR = 16,
  parameter int         K    = 239,
  parameter logic [8:0] PRIM = 9'h11D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [8*NPAR-1:0] g_coef,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);
  typedef enum logic [1:0] {IDLE, MSG, PAR} state_t;

  localparam logic [7:0] K_LAST = 8'(K - 1);
  localparam logic [5:0] P_LAST = 6'(NPAR - 1);

  state_t                r_state;
  logic [NPAR-1:0][7:0]  r_par;
  logic [7:0]            r_msg_cnt;
  logic [5:0]            r_par_cnt;
  logic [7:0]            r_out_data;
  logic                  r_out_valid;
  logic                  r_out_last;

  logic [NPAR-1:0][7:0]  w_prod;
  logic [7:0]            w_fb;
  logic                  w_out_adv;
  logic                  w_in_fire;
  logic                  w_msg_last;
  logic                  w_par_last;

  assign w_out_adv  = ~r_out_valid | out_ready;
  // Gated by rst so that nothing is accepted while the block is in reset.
  assign in_ready   = rst & (r_state != PAR) & w_out_adv;
  assign w_in_fire  = in_valid & in_ready;
  assign w_msg_last = (r_msg_cnt == K_LAST);
  assign w_par_last = (r_par_cnt == P_LAST);
  assign w_fb       = in_data ^ r_par[NPAR-1];

  // One multiplier per LFSR tap, each scaling the feedback symbol.
  for (genvar gi = 0; gi < NPAR; gi++) begin : g_tap
    rs_gf_mul #(.PRIM(PRIM)) u_mul (
      .i_a (w_fb),
      .i_b (g_coef[8*gi +: 8]),
      .o_p (w_prod[gi])
    );
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_par       <= '0;
      r_msg_cnt   <= '0;
      r_par_cnt   <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      case (r_state)
        IDLE, MSG: begin
          // Without out_adv, everything holds (output stalled).
          if (w_out_adv) begin
            if (w_in_fire) begin
              r_out_data  <= in_data;
              r_out_valid <= 1'b1;
              r_out_last  <= 1'b0;
              r_par[0]    <= w_prod[0];
              for (int i = 1; i < NPAR; i++)
                r_par[i] <= r_par[i-1] ^ w_prod[i];
              if (w_msg_last) begin
                r_msg_cnt <= '0;
                r_state   <= PAR;
              end else begin
                r_msg_cnt <= r_msg_cnt + 8'd1;
                r_state   <= MSG;
              end
            end else begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end
          end
        end
        PAR: begin
          if (w_out_adv) begin
            r_out_data  <= r_par[NPAR-1];
            r_out_valid <= 1'b1;
            r_out_last  <= w_par_last;
            if (w_par_last) begin
              r_par     <= '0;
              r_par_cnt <= '0;
              r_state   <= IDLE;
            end else begin
              r_par     <= {r_par[NPAR-2:0], 8'h00};
              r_par_cnt <= r_par_cnt + 6'd1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rs_enc_lfsr.sv
// Scoreboarded bench for rs_enc_lfsr. It uses a small instance (NPAR=2, K=3)
// for directed cases and a default-parameter instance for random codewords,
// which are checked against polynomial long division over GF(2^8).
module tb_rs_enc_lfsr;
  localparam int SN = 2;
  localparam int SK = 3;
  localparam int BN = 16;
  localparam int BK = 239;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic [8*SN-1:0] s_g = 16'h0608;
  logic [7:0] s_in_data, s_out_data;
  logic s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_out_last;

  logic [8*BN-1:0] b_g;
  logic [7:0] b_in_data, b_out_data;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last;
  bit   b_rand = 1'b0;

  rs_enc_lfsr #(.NPAR(SN), .K(SK), .PRIM(9'h11D)) u_small (
    .clk(clk), .rst(rst), .g_coef(s_g), .in_data(s_in_data), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .out_data(s_out_data), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .out_last(s_out_last));

  rs_enc_lfsr u_big (
    .clk(clk), .rst(rst), .g_coef(b_g), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_last(b_out_last));

  int n_chk = 0;
  int n_fail = 0;
  int exp_s[$];
  int exp_b[$];
  int gexp[0:254];
  int glog[0:255];
  int gc_b[0:BN-1];
  logic [7:0] mm[0:BK-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int gmul(input int a, input int b);
    if (a == 0 || b == 0) return 0;
    return gexp[(glog[a] + glog[b]) % 255];
  endfunction

  // Reference: message(x)*x^NPAR divided by the monic generator g(x);
  // the remainder, highest degree first, is the parity sequence.
  task automatic push_big();
    int c[0:BK+BN-1];
    for (int i = 0; i < BK; i++) c[i] = mm[i];
    for (int i = 0; i < BN; i++) c[BK+i] = 0;
    for (int i = 0; i < BK; i++)
      for (int j = 1; j <= BN; j++)
        c[i+j] = c[i+j] ^ gmul(c[i], gc_b[BN-j]);
    for (int i = 0; i < BK; i++) exp_b.push_back(int'(mm[i]));
    for (int j = 0; j < BN; j++) exp_b.push_back(c[BK+j] | ((j == BN-1) ? 256 : 0));
  endtask

  task automatic s_push(input int v, input bit last);
    exp_s.push_back(v | (last ? 256 : 0));
  endtask

  task automatic s_push_basic();
    s_push(1, 0); s_push(0, 0); s_push(0, 0); s_push(120, 0); s_push(224, 1);
  endtask

  task automatic s_send(input logic [7:0] d);
    bit f = 1'b0;
    s_in_data = d;
    s_in_valid = 1'b1;
    for (int t = 0; t < 200 && !f; t++) begin
      @(negedge clk); f = s_in_ready;
      @(posedge clk); #1;
    end
    if (!f) chk("small in_ready timeout", {31'b0, f}, 1);
    s_in_valid = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] d);
    bit f = 1'b0;
    if ($urandom_range(0, 99) < 25) begin
      b_in_valid = 1'b0;
      repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    b_in_data = d;
    b_in_valid = 1'b1;
    for (int t = 0; t < 400 && !f; t++) begin
      @(negedge clk); f = b_in_ready;
      @(posedge clk); #1;
    end
    if (!f) chk("big in_ready timeout", {31'b0, f}, 1);
    b_in_valid = 1'b0;
  endtask

  task automatic s_drain();
    for (int t = 0; t < 300 && exp_s.size() != 0; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("small drain", exp_s.size(), 0);
  endtask

  // Monitors: pop and compare on every output transfer.
  always @(negedge clk) begin : mon_s
    int e;
    if (rst === 1'b1 && s_out_valid && s_out_ready) begin
      if (exp_s.size() == 0) chk("small unexpected output", {23'b0, s_out_last, s_out_data}, 32'hFFFF);
      else begin
        e = exp_s.pop_front();
        chk("small data", s_out_data, e & 255);
        chk("small last", s_out_last, (e >> 8) & 1);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    int e;
    if (rst === 1'b1 && b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) chk("big unexpected output", {23'b0, b_out_last, b_out_data}, 32'hFFFF);
      else begin
        e = exp_b.pop_front();
        chk("big data", b_out_data, e & 255);
        chk("big last", b_out_last, (e >> 8) & 1);
      end
    end
  end

  initial begin
    b_out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      b_out_ready = b_rand ? ($urandom_range(0, 99) < 65) : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_reset();
    @(negedge clk);
    chk("rst small out_valid", s_out_valid, 0);
    chk("rst small out_last", s_out_last, 0);
    chk("rst small out_data", s_out_data, 0);
    chk("rst small in_ready", s_in_ready, 0);
    chk("rst big out_valid", b_out_valid, 0);
    chk("rst big in_ready", b_in_ready, 0);
  endtask

  initial begin
    int x;
    int gp[0:BN];
    bit found;
    // log/antilog tables for alpha = 2 under 0x11D
    x = 1;
    for (int i = 0; i < 255; i++) begin
      gexp[i] = x; glog[x] = i;
      x = x << 1;
      if (x & 256) x = x ^ 'h11D;
    end
    // RS(255,239) generator: product of (x + alpha^i), i = 0..15
    for (int i = 0; i <= BN; i++) gp[i] = (i == 0) ? 1 : 0;
    for (int i = 0; i < BN; i++) begin
      for (int j = i + 1; j >= 1; j--) gp[j] = gp[j-1] ^ gmul(gp[j], gexp[i]);
      gp[0] = gmul(gp[0], gexp[i]);
    end
    for (int i = 0; i < BN; i++) begin
      gc_b[i] = gp[i];
      b_g[8*i +: 8] = 8'(gp[i]);
    end

    rst = 1'b0;
    s_in_data = '0; s_in_valid = 1'b0; s_out_ready = 1'b1;
    b_in_data = '0; b_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    check_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("idle in_ready", s_in_ready, 1);
    @(posedge clk); #1;

    // basic codeword
    s_push_basic();
    s_send(8'd1); s_send(8'd0); s_send(8'd0);
    s_drain();

    // output backpressure held on the first parity symbol
    s_push_basic();
    found = 1'b0;
    fork
      begin s_send(8'd1); s_send(8'd0); s_send(8'd0); end
      begin
        for (int t = 0; t < 60 && !found; t++) begin
          @(posedge clk); #1;
          if (s_out_valid && s_out_data == 8'd120) begin
            s_out_ready = 1'b0;
            found = 1'b1;
          end
        end
        if (found) begin
          for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp hold data", s_out_data, 120);
            chk("bp hold valid", s_out_valid, 1);
            chk("bp hold last", s_out_last, 0);
            chk("bp in_ready", s_in_ready, 0);
            @(posedge clk); #1;
          end
        end
        s_out_ready = 1'b1;
      end
    join
    chk("bp parity seen", {31'b0, found}, 1);
    s_drain();

    // input bubbles between every symbol
    s_push_basic();
    s_send(8'd1); @(posedge clk); #1;
    s_send(8'd0); @(posedge clk); #1;
    s_send(8'd0);
    s_drain();

    // reset mid-codeword discards the partial word
    s_push(1, 0); s_push(5, 0);
    s_send(8'd1); s_send(8'd5);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    check_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    s_push_basic();
    s_send(8'd1); s_send(8'd0); s_send(8'd0);
    s_drain();
    repeat (10) @(posedge clk);
    #1;

    // back-to-back: zero message then 1,0,0
    s_push(0, 0); s_push(0, 0); s_push(0, 0); s_push(0, 0); s_push(0, 1);
    s_push_basic();
    s_send(8'd0); s_send(8'd0); s_send(8'd0);
    s_send(8'd1); s_send(8'd0); s_send(8'd0);
    s_drain();

    // random RS(255,239) codewords with random valid/ready
    b_rand = 1'b1;
    for (int cw = 0; cw < 5; cw++) begin
      for (int i = 0; i < BK; i++) mm[i] = 8'($urandom_range(0, 255));
      push_big();
      for (int i = 0; i < BK; i++) b_send(mm[i]);
    end
    for (int t = 0; t < 3000 && exp_b.size() != 0; t++) @(posedge clk);
    b_rand = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("big drain", exp_b.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
